// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// The producer/consumer side takes master, the adder takes slave.
interface pipelined_addsub_if #(parameter int N = 8);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         c_out;
  logic         ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );
  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined N-bit signed add/sub: carry chain cut into STAGES slices, one
// register per slice, valid/ready flow control with full-rate backpressure.
module pipelined_addsub_stage #(
  parameter int N = 8,
  parameter int W = 4,
  parameter int K = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         adv,
  input  logic [N-1:0] a_d,
  input  logic [N-1:0] b_d,
  input  logic [N-1:0] res_d,
  input  logic         c_d,
  output logic         vld,
  output logic [N-1:0] a_q,
  output logic [N-1:0] b_q,
  output logic [N-1:0] res_q,
  output logic         c_q,
  output logic         ct_q
);
  logic [W-1:0] a_sl, b_sl, s_sl;
  logic         co;
  logic [N-1:0] res_nx;

  assign a_sl = a_d[K*W +: W];
  assign b_sl = b_d[K*W +: W];
  assign {co, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{W{1'b0}}, c_d};

  always_comb begin
    res_nx = res_d;
    res_nx[K*W +: W] = s_sl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      c_q   <= 1'b0;
      ct_q  <= 1'b0;
    end else if (ld) begin
      vld   <= 1'b1;
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_nx;
      c_q   <= co;
      // sum bit = a ^ b ^ carry-in, so the carry into the slice MSB falls out by xor
      ct_q  <= s_sl[W-1] ^ a_sl[W-1] ^ b_sl[W-1];
    end else if (adv) begin
      vld   <= 1'b0;
    end
  end
endmodule

module pipelined_addsub #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  pipelined_addsub_if.slave  bus
);
  localparam int W = N / STAGES;

  if (N < 2 || STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_param
    $error("pipelined_addsub: N must be >= 2 and a multiple of STAGES (1..N)");
  end

  // index k feeds stage k; index k+1 is stage k's register
  logic [STAGES:0][N-1:0] a_r, b_r, res_r;
  logic [STAGES:0]        c_r;
  logic [STAGES-1:0]      ct_r;
  logic [STAGES-1:0]      vld_pipe, adv, ld;
  logic                   acc;
  logic                   unused_tail;

  assign a_r[0]   = bus.a;
  assign b_r[0]   = bus.sub ? ~bus.b : bus.b;
  assign res_r[0] = '0;
  assign c_r[0]   = bus.sub ? ~bus.c_in : bus.c_in;

  // advance chain runs from the output back toward the input
  always_comb begin
    adv = '0;
    adv[STAGES-1] = vld_pipe[STAGES-1] && bus.out_ready && !rst;
    for (int k = STAGES - 2; k >= 0; k--)
      adv[k] = vld_pipe[k] && (!vld_pipe[k+1] || adv[k+1]);
  end

  assign acc = !rst && (!vld_pipe[0] || adv[0]);

  always_comb begin
    ld = '0;
    ld[0] = bus.in_valid && acc;
    for (int k = 1; k < STAGES; k++)
      ld[k] = adv[k-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipelined_addsub_stage #(.N(N), .W(W), .K(k)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .ld    (ld[k]),
      .adv   (adv[k]),
      .a_d   (a_r[k]),
      .b_d   (b_r[k]),
      .res_d (res_r[k]),
      .c_d   (c_r[k]),
      .vld   (vld_pipe[k]),
      .a_q   (a_r[k+1]),
      .b_q   (b_r[k+1]),
      .res_q (res_r[k+1]),
      .c_q   (c_r[k+1]),
      .ct_q  (ct_r[k])
    );
  end

  assign bus.in_ready  = acc;
  assign bus.out_valid = vld_pipe[STAGES-1] && !rst;
  assign bus.sum       = res_r[STAGES];
  assign bus.c_out     = c_r[STAGES];
  assign bus.ovf       = c_r[STAGES] ^ ct_r[STAGES-1];

  assign unused_tail = ^{a_r[STAGES], b_r[STAGES], ct_r};
endmodule
